// File: rtl/stack_pointer_unit.sv
// Main-stack and return-stack pointer unit for the JALA datapath.
// Both stacks grow downward in word-addressed memory; depth is tracked and over/underflow latched.
module stack_pointer_unit #(
  parameter logic [15:0] MS_EMPTY = 16'h8000,
  parameter int          MS_DEPTH = 256,
  parameter logic [15:0] RS_EMPTY = 16'hF000,
  parameter int          RS_DEPTH = 64
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        MSPWrite,
  input  logic        MSPop,
  input  logic        MSPRegReset,
  input  logic        RSPWrite,
  input  logic        RSPop,
  input  logic        RSPRegReset,
  output logic [15:0] MSP,
  output logic [15:0] MSSecond,
  output logic [15:0] RSP,
  output logic [15:0] MSDepth,
  output logic [15:0] RSDepth,
  output logic        MSFault,
  output logic        RSFault,
  output logic        stackFault
);

  localparam logic [15:0] MS_MAX = 16'(MS_DEPTH);
  localparam logic [15:0] RS_MAX = 16'(RS_DEPTH);

  // Main stack: a rejected push/pop holds pointer and depth and only raises the sticky fault.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      MSP     <= MS_EMPTY;
      MSDepth <= 16'd0;
      MSFault <= 1'b0;
    end else if (MSPRegReset) begin
      MSP     <= MS_EMPTY;
      MSDepth <= 16'd0;
      MSFault <= 1'b0;
    end else if (MSPWrite) begin
      if (!MSPop) begin
        if (MSDepth < MS_MAX) begin
          MSP     <= MSP - 16'd1;
          MSDepth <= MSDepth + 16'd1;
        end else begin
          MSFault <= 1'b1;
        end
      end else begin
        if (MSDepth != 16'd0) begin
          MSP     <= MSP + 16'd1;
          MSDepth <= MSDepth - 16'd1;
        end else begin
          MSFault <= 1'b1;
        end
      end
    end
  end

  // Return stack: same rules, fully independent of the main stack.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      RSP     <= RS_EMPTY;
      RSDepth <= 16'd0;
      RSFault <= 1'b0;
    end else if (RSPRegReset) begin
      RSP     <= RS_EMPTY;
      RSDepth <= 16'd0;
      RSFault <= 1'b0;
    end else if (RSPWrite) begin
      if (!RSPop) begin
        if (RSDepth < RS_MAX) begin
          RSP     <= RSP - 16'd1;
          RSDepth <= RSDepth + 16'd1;
        end else begin
          RSFault <= 1'b1;
        end
      end else begin
        if (RSDepth != 16'd0) begin
          RSP     <= RSP + 16'd1;
          RSDepth <= RSDepth - 16'd1;
        end else begin
          RSFault <= 1'b1;
        end
      end
    end
  end

  // Second entry is not gated by depth; consumers must qualify it with MSDepth >= 2.
  assign MSSecond   = MSP + 16'd1;
  assign stackFault = MSFault | RSFault;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed plus randomized bench for stack_pointer_unit against a depth-counting reference model.
module tb_stack_pointer_unit;

  localparam logic [15:0] MS_E = 16'h8000;
  localparam logic [15:0] RS_E = 16'hF000;
  localparam int MS_D = 256;
  localparam int RS_D = 64;

  logic CLK, rst;
  logic MSPWrite, MSPop, MSPRegReset, RSPWrite, RSPop, RSPRegReset;
  logic [15:0] MSP, MSSecond, RSP, MSDepth, RSDepth;
  logic MSFault, RSFault, stackFault;

  int errors = 0;
  int checks = 0;

  // Reference model: only entry counts and fault bits; pointers derive from depth.
  int msD, rsD;
  bit msF, rsF;

  stack_pointer_unit #(
    .MS_EMPTY(MS_E), .MS_DEPTH(MS_D), .RS_EMPTY(RS_E), .RS_DEPTH(RS_D)
  ) dut (
    .CLK(CLK), .rst(rst),
    .MSPWrite(MSPWrite), .MSPop(MSPop), .MSPRegReset(MSPRegReset),
    .RSPWrite(RSPWrite), .RSPop(RSPop), .RSPRegReset(RSPRegReset),
    .MSP(MSP), .MSSecond(MSSecond), .RSP(RSP),
    .MSDepth(MSDepth), .RSDepth(RSDepth),
    .MSFault(MSFault), .RSFault(RSFault), .stackFault(stackFault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [15:0] msPtr, rsPtr;
    msPtr = MS_E - 16'(msD);
    rsPtr = RS_E - 16'(rsD);
    check({tag, ".MSP"}, MSP, msPtr);
    check({tag, ".MSSecond"}, MSSecond, msPtr + 16'd1);
    check({tag, ".RSP"}, RSP, rsPtr);
    check({tag, ".MSDepth"}, MSDepth, 16'(msD));
    check({tag, ".RSDepth"}, RSDepth, 16'(rsD));
    check({tag, ".MSFault"}, {15'd0, MSFault}, {15'd0, msF});
    check({tag, ".RSFault"}, {15'd0, RSFault}, {15'd0, rsF});
    check({tag, ".stackFault"}, {15'd0, stackFault}, {15'd0, msF | rsF});
  endtask

  task automatic modelStack(input logic clr, input logic wr, input logic pop, input int maxD,
                            inout int d, inout bit f);
    if (clr) begin
      d = 0;
      f = 1'b0;
    end else if (wr) begin
      if (!pop) begin
        if (d < maxD) d = d + 1;
        else f = 1'b1;
      end else begin
        if (d > 0) d = d - 1;
        else f = 1'b1;
      end
    end
  endtask

  task automatic modelReset();
    msD = 0; rsD = 0; msF = 1'b0; rsF = 1'b0;
  endtask

  // One clock edge with the given strobes, then compare everything just after the edge.
  task automatic cyc(input string tag, input logic msw, input logic msp, input logic msr,
                     input logic rsw, input logic rsp, input logic rsr);
    MSPWrite = msw; MSPop = msp; MSPRegReset = msr;
    RSPWrite = rsw; RSPop = rsp; RSPRegReset = rsr;
    @(posedge CLK);
    modelStack(msr, msw, msp, MS_D, msD, msF);
    modelStack(rsr, rsw, rsp, RS_D, rsD, rsF);
    #1;
    checkAll(tag);
  endtask

  task automatic idle();
    MSPWrite = 0; MSPop = 0; MSPRegReset = 0;
    RSPWrite = 0; RSPop = 0; RSPRegReset = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    modelReset();
    #12;
    checkAll("reset");
    check("reset.MSSecondLit", MSSecond, 16'h8001);
    rst = 1'b0;

    // Push/pop on the main stack
    for (int i = 0; i < 3; i++) cyc("msPush", 1, 0, 0, 0, 0, 0);
    check("push3.MSP", MSP, 16'h7FFD);
    check("push3.MSSecond", MSSecond, 16'h7FFE);
    for (int i = 0; i < 2; i++) cyc("msPop", 1, 1, 0, 0, 0, 0);
    check("pop2.MSP", MSP, 16'h7FFF);
    cyc("idle", 0, 1, 0, 0, 1, 0);

    // Return-stack underflow, sticky fault, then clear
    cyc("rsUnder", 0, 0, 0, 1, 1, 0);
    check("rsUnder.RSFault", {15'd0, RSFault}, 16'd1);
    cyc("rsPushFaulted", 0, 0, 0, 1, 0, 0);
    check("rsPushFaulted.RSP", RSP, 16'hEFFF);
    cyc("rsClear", 0, 0, 0, 0, 0, 1);
    check("rsClear.RSP", RSP, 16'hF000);

    // Return-stack overflow
    for (int i = 0; i < 64; i++) cyc("rsFill", 0, 0, 0, 1, 0, 0);
    check("rsFull.RSP", RSP, 16'hEFC0);
    cyc("rsOver", 0, 0, 0, 1, 0, 0);
    check("rsOver.RSFault", {15'd0, RSFault}, 16'd1);
    check("rsOver.MSFault", {15'd0, MSFault}, 16'd0);
    cyc("rsClear2", 0, 0, 0, 0, 0, 1);

    // Main-stack overflow at full depth
    for (int i = 0; i < MS_D; i++) cyc("msFill", 1, 0, 0, 0, 0, 0);
    check("msFull.MSP", MSP, 16'h7F00);
    cyc("msOver", 1, 0, 0, 1, 0, 0);
    cyc("msClear", 0, 0, 1, 0, 0, 1);

    // Simultaneous RegReset + write on MS while RS pushes
    for (int i = 0; i < 5; i++) cyc("msPush5", 1, 0, 0, 0, 0, 0);
    cyc("simul", 1, 0, 1, 1, 0, 0);
    check("simul.MSP", MSP, 16'h8000);
    check("simul.RSP", RSP, 16'hEFFF);

    // Asynchronous reset mid-operation with MSPWrite held high
    cyc("prep", 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("msPush4", 1, 0, 0, 0, 0, 0);
    MSPWrite = 1; MSPop = 0;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll("asyncRst");
    #2;
    rst = 1'b0;
    cyc("afterRst", 1, 0, 0, 0, 0, 0);
    check("afterRst.MSDepth", MSDepth, 16'd1);

    // Randomized strobes against the model
    for (int i = 0; i < 600; i++) begin
      logic msw, msp, msr, rsw, rsp, rsr;
      msw = ($urandom_range(0, 3) != 0);
      msp = ($urandom_range(0, 9) < 4);
      msr = ($urandom_range(0, 63) == 0);
      rsw = ($urandom_range(0, 3) != 0);
      rsp = ($urandom_range(0, 9) < 4);
      rsr = ($urandom_range(0, 47) == 0);
      cyc("rand", msw, msp, msr, rsw, rsp, rsr);
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
